// File: rtl/trap_sequencer.sv
// Machine-mode trap entry / mret sequencer: arbitrates interrupts, stalls the pipeline,
// walks the ordered CSR accesses through the single CSR port and redirects fetch.
module trap_sequencer #(
    parameter logic [31:0] TIMER_CAUSE = 32'h8000_0007,
    parameter logic [31:0] EXT_CAUSE   = 32'h8000_000B
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        instr_valid,
    input  logic        is_mret,
    input  logic        MTI,
    input  logic        EI,
    input  logic [31:0] csr_mstatus,
    input  logic [31:0] csr_mie,
    input  logic [31:0] csr_rdata,
    output logic [11:0] csr_addr,
    output logic [31:0] csr_wdata,
    output logic        csr_we,
    output logic        csr_rd,
    output logic        stall,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        trap_taken
);

    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_SAVE_EPC    = 3'd1;
    localparam logic [2:0] S_SAVE_CAUSE  = 3'd2;
    localparam logic [2:0] S_UPD_STATUS  = 3'd3;
    localparam logic [2:0] S_READ_VEC    = 3'd4;
    localparam logic [2:0] S_MRET_STATUS = 3'd5;
    localparam logic [2:0] S_READ_EPC    = 3'd6;
    localparam logic [2:0] S_REDIRECT    = 3'd7;

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

    logic [2:0]  state_q, state_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] target_q, target_d;
    logic        is_trap_q, is_trap_d;

    logic        ext_p, tmr_p, take_trap, take_mret;
    logic [31:0] vec_base, vec_target;

    assign ext_p     = EI  & csr_mie[11] & csr_mstatus[3];
    assign tmr_p     = MTI & csr_mie[7]  & csr_mstatus[3];
    // An interrupt pre-empts a committing mret; that mret's PC becomes mepc.
    assign take_trap = instr_valid & (ext_p | tmr_p);
    assign take_mret = instr_valid & is_mret & ~(ext_p | tmr_p);

    assign vec_base   = {csr_rdata[31:2], 2'b00};
    assign vec_target = (csr_rdata[1:0] == 2'b01) ? vec_base + {25'd0, cause_q[4:0], 2'b00}
                                                  : vec_base;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d     = state_q;
        epc_d       = epc_q;
        cause_d     = cause_q;
        target_d    = target_q;
        is_trap_d   = is_trap_q;
        csr_addr    = '0;
        csr_wdata   = '0;
        csr_we      = 1'b0;
        csr_rd      = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        trap_taken  = 1'b0;
        stall       = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (take_trap) begin
                    epc_d     = pc;
                    cause_d   = ext_p ? EXT_CAUSE : TIMER_CAUSE;
                    is_trap_d = 1'b1;
                    stall     = 1'b1;
                    state_d   = S_SAVE_EPC;
                end else if (take_mret) begin
                    is_trap_d = 1'b0;
                    stall     = 1'b1;
                    state_d   = S_MRET_STATUS;
                end
            end
            S_SAVE_EPC: begin
                csr_we    = 1'b1;
                csr_addr  = ADDR_MEPC;
                csr_wdata = epc_q;
                state_d   = S_SAVE_CAUSE;
            end
            S_SAVE_CAUSE: begin
                csr_we    = 1'b1;
                csr_addr  = ADDR_MCAUSE;
                csr_wdata = cause_q;
                state_d   = S_UPD_STATUS;
            end
            S_UPD_STATUS: begin
                csr_we           = 1'b1;
                csr_addr         = ADDR_MSTATUS;
                csr_wdata        = csr_mstatus;
                csr_wdata[7]     = csr_mstatus[3];
                csr_wdata[3]     = 1'b0;
                csr_wdata[12:11] = 2'b11;
                state_d          = S_READ_VEC;
            end
            S_READ_VEC: begin
                csr_rd   = 1'b1;
                csr_addr = ADDR_MTVEC;
                target_d = vec_target;
                state_d  = S_REDIRECT;
            end
            S_MRET_STATUS: begin
                csr_we           = 1'b1;
                csr_addr         = ADDR_MSTATUS;
                csr_wdata        = csr_mstatus;
                csr_wdata[3]     = csr_mstatus[7];
                csr_wdata[7]     = 1'b1;
                csr_wdata[12:11] = 2'b00;
                state_d          = S_READ_EPC;
            end
            S_READ_EPC: begin
                csr_rd   = 1'b1;
                csr_addr = ADDR_MEPC;
                target_d = csr_rdata;
                state_d  = S_REDIRECT;
            end
            S_REDIRECT: begin
                redirect    = 1'b1;
                redirect_pc = target_q;
                trap_taken  = is_trap_q;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Reset aborts the sequence in the very cycle it is raised: no access leaks out.
        if (reset) begin
            csr_addr    = '0;
            csr_wdata   = '0;
            csr_we      = 1'b0;
            csr_rd      = 1'b0;
            redirect    = 1'b0;
            redirect_pc = '0;
            trap_taken  = 1'b0;
            stall       = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            epc_q     <= '0;
            cause_q   <= '0;
            target_q  <= '0;
            is_trap_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            epc_q     <= epc_d;
            cause_q   <= cause_d;
            target_q  <= target_d;
            is_trap_q <= is_trap_d;
        end
    end

endmodule

// File: tb/tb_trap_sequencer.sv
// Bench for trap_sequencer: emulates the CSR file and predicts every cycle of each
// trap / mret sequence from the architectural rules, for directed and random requests.
module tb_trap_sequencer;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic        instr_valid;
    logic        is_mret;
    logic        MTI;
    logic        EI;
    logic [31:0] csr_mstatus;
    logic [31:0] csr_mie;
    logic [31:0] csr_rdata;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        csr_we;
    logic        csr_rd;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        trap_taken;

    // Architectural CSR state seen by the DUT
    logic [31:0] m_mstatus, m_mie, m_mtvec, m_mepc, m_mcause;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        stall;
        logic        we;
        logic        rd;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic        redirect;
        logic [31:0] rpc;
        logic        trap;
    } exp_t;

    trap_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .instr_valid (instr_valid),
        .is_mret     (is_mret),
        .MTI         (MTI),
        .EI          (EI),
        .csr_mstatus (csr_mstatus),
        .csr_mie     (csr_mie),
        .csr_rdata   (csr_rdata),
        .csr_addr    (csr_addr),
        .csr_wdata   (csr_wdata),
        .csr_we      (csr_we),
        .csr_rd      (csr_rd),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .trap_taken  (trap_taken)
    );

    assign csr_mstatus = m_mstatus;
    assign csr_mie     = m_mie;
    assign csr_rdata   = (csr_addr == 12'h300) ? m_mstatus :
                         (csr_addr == 12'h305) ? m_mtvec   :
                         (csr_addr == 12'h341) ? m_mepc    :
                         (csr_addr == 12'h342) ? m_mcause  : 32'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".stall"},    {31'd0, stall},    32'd0);
        check({tag, ".csr_we"},   {31'd0, csr_we},   32'd0);
        check({tag, ".csr_rd"},   {31'd0, csr_rd},   32'd0);
        check({tag, ".redirect"}, {31'd0, redirect}, 32'd0);
        check({tag, ".trap"},     {31'd0, trap_taken}, 32'd0);
        check({tag, ".addr"},     {20'd0, csr_addr}, 32'd0);
        check({tag, ".wdata"},    csr_wdata,         32'd0);
        check({tag, ".rpc"},      redirect_pc,       32'd0);
    endtask

    // One clock cycle: compare outputs at the falling edge, then commit the predicted write.
    task automatic step(input exp_t e);
        @(negedge clk);
        check("stall",    {31'd0, stall},      {31'd0, e.stall});
        check("csr_we",   {31'd0, csr_we},     {31'd0, e.we});
        check("csr_rd",   {31'd0, csr_rd},     {31'd0, e.rd});
        check("csr_addr", {20'd0, csr_addr},   {20'd0, e.addr});
        if (!e.rd) check("csr_wdata", csr_wdata, e.wdata);
        check("redirect", {31'd0, redirect},   {31'd0, e.redirect});
        check("redirect_pc", redirect_pc,      e.rpc);
        check("trap_taken", {31'd0, trap_taken}, {31'd0, e.trap});
        @(posedge clk);
        #1;
        if (e.we) begin
            case (e.addr)
                12'h300: m_mstatus = e.wdata;
                12'h341: m_mepc    = e.wdata;
                12'h342: m_mcause  = e.wdata;
                default: ;
            endcase
        end
    endtask

    task automatic scramble_inputs();
        pc          = $urandom;
        instr_valid = 1'($urandom);
        is_mret     = 1'($urandom);
        MTI         = 1'($urandom);
        EI          = 1'($urandom);
    endtask

    task automatic clear_inputs();
        pc          = 32'd0;
        instr_valid = 1'b0;
        is_mret     = 1'b0;
        MTI         = 1'b0;
        EI          = 1'b0;
    endtask

    // Present one commit request and follow whatever sequence the rules predict for it.
    task automatic run_op(input logic [31:0] p, input logic v, input logic m,
                          input logic mti, input logic ei);
        exp_t        q[$];
        exp_t        e;
        logic        ext, tmr;
        logic [31:0] cause, base, tgt, ms;
        pc          = p;
        instr_valid = v;
        is_mret     = m;
        MTI         = mti;
        EI          = ei;
        ext = ei  & m_mie[11] & m_mstatus[3];
        tmr = mti & m_mie[7]  & m_mstatus[3];
        if (v && (ext || tmr)) begin
            cause = ext ? 32'h8000_000B : 32'h8000_0007;
            e = '0; e.stall = 1'b1; q.push_back(e);
            e = '0; e.stall = 1'b1; e.we = 1'b1; e.addr = 12'h341; e.wdata = p;     q.push_back(e);
            e = '0; e.stall = 1'b1; e.we = 1'b1; e.addr = 12'h342; e.wdata = cause; q.push_back(e);
            ms = (m_mstatus & ~32'h0000_1888) | 32'h0000_1800 | (m_mstatus[3] ? 32'h80 : 32'h0);
            e = '0; e.stall = 1'b1; e.we = 1'b1; e.addr = 12'h300; e.wdata = ms;    q.push_back(e);
            e = '0; e.stall = 1'b1; e.rd = 1'b1; e.addr = 12'h305;                  q.push_back(e);
            base = m_mtvec & ~32'd3;
            tgt  = (m_mtvec % 4 == 1) ? base + (cause % 32) * 4 : base;
            e = '0; e.stall = 1'b1; e.redirect = 1'b1; e.rpc = tgt; e.trap = 1'b1;  q.push_back(e);
        end else if (v && m) begin
            e = '0; e.stall = 1'b1; q.push_back(e);
            ms = (m_mstatus & ~32'h0000_1888) | 32'h80 | (m_mstatus[7] ? 32'h8 : 32'h0);
            e = '0; e.stall = 1'b1; e.we = 1'b1; e.addr = 12'h300; e.wdata = ms;    q.push_back(e);
            e = '0; e.stall = 1'b1; e.rd = 1'b1; e.addr = 12'h341;                  q.push_back(e);
            e = '0; e.stall = 1'b1; e.redirect = 1'b1; e.rpc = m_mepc;              q.push_back(e);
        end else begin
            e = '0; q.push_back(e);
        end
        for (int i = 0; i < q.size(); i++) begin
            step(q[i]);
            if (i != q.size() - 1) scramble_inputs();
        end
        clear_inputs();
    endtask

    initial begin
        exp_t e;
        reset     = 1'b1;
        clear_inputs();
        m_mstatus = 32'd0;
        m_mie     = 32'd0;
        m_mtvec   = 32'd0;
        m_mepc    = 32'd0;
        m_mcause  = 32'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_quiet("reset_state");
        @(posedge clk);
        #1;

        // Timer interrupt, direct mtvec
        m_mie = 32'h80; m_mstatus = 32'h8; m_mtvec = 32'h2000;
        run_op(32'h100, 1'b1, 1'b0, 1'b1, 1'b0);
        check("tmr.mepc",    m_mepc,    32'h100);
        check("tmr.mcause",  m_mcause,  32'h8000_0007);
        check("tmr.mstatus", m_mstatus, 32'h1880);

        // Both interrupts, vectored mtvec: external wins
        m_mie = 32'h880; m_mstatus = 32'h8; m_mtvec = 32'h2001;
        run_op(32'h100, 1'b1, 1'b0, 1'b1, 1'b1);
        check("ext.mcause", m_mcause, 32'h8000_000B);

        // mret back to 0x100
        m_mstatus = 32'h1880; m_mepc = 32'h100;
        run_op(32'h2040, 1'b1, 1'b1, 1'b0, 1'b0);
        check("mret.mstatus", m_mstatus, 32'h88);

        // Masked timer: globally disabled, then locally disabled
        m_mstatus = 32'h0; m_mie = 32'h80;
        run_op(32'h300, 1'b1, 1'b0, 1'b1, 1'b0);
        m_mstatus = 32'h8; m_mie = 32'h0;
        run_op(32'h300, 1'b1, 1'b0, 1'b1, 1'b0);

        // Timer coincident with mret: trap wins
        m_mstatus = 32'h8; m_mie = 32'h80; m_mtvec = 32'h2000;
        run_op(32'h200, 1'b1, 1'b1, 1'b1, 1'b0);
        check("mret_irq.mepc",    m_mepc,    32'h200);
        check("mret_irq.mstatus", m_mstatus, 32'h1880);

        // Reset raised while UPD_STATUS is active
        m_mstatus = 32'h8; m_mie = 32'h80; m_mtvec = 32'h2000;
        pc = 32'h300; instr_valid = 1'b1; MTI = 1'b1;
        e = '0; e.stall = 1'b1; step(e);
        clear_inputs();
        e = '0; e.stall = 1'b1; e.we = 1'b1; e.addr = 12'h341; e.wdata = 32'h300;       step(e);
        e = '0; e.stall = 1'b1; e.we = 1'b1; e.addr = 12'h342; e.wdata = 32'h8000_0007; step(e);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_quiet("after_reset");
        @(posedge clk);
        #1;
        check("after_reset.mstatus", m_mstatus, 32'h8);
        run_op(32'h300, 1'b1, 1'b0, 1'b1, 1'b0);

        // Random requests against the rule model
        for (int n = 0; n < 60; n++) begin
            m_mie     = ($urandom & 32'h0000_0880) | ($urandom & ~32'h0000_0880);
            m_mstatus = $urandom;
            m_mtvec   = $urandom;
            m_mepc    = $urandom;
            run_op($urandom, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
